serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  first operand; captured on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  second operand; captured on an accepted start.
REQ-007 SHALL have port cin  input  1  carry-in; captured on an accepted start.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress (RUN state).
REQ-009 SHALL have port done  output  1  single-cycle pulse marking a valid result.
REQ-010 SHALL have port sum  output  WIDTH  result bits, equal to (a+b+cin) mod 2^WIDTH.
REQ-011 SHALL have port cout  output  1  carry-out, equal to bit WIDTH of a+b+cin.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1, capture a, b and cin, clear the bit counter, and move to RUN on the next edge.
REQ-014 SHALL ignore start in IDLE when it is low; the FSM stays in IDLE.
REQ-015 SHALL process exactly one bit per RUN cycle, LSB first, using one full-add slice:
- sum bit = a_i ^ b_i ^ c
- next c = (a_i & b_i) | ((a_i ^ b_i) & c)
REQ-016 SHALL shift each sum bit into the result register from the MSB end, so that after WIDTH shifts bit 0 sits at sum[0].
REQ-017 SHALL leave RUN for DONE after exactly WIDTH RUN cycles.
REQ-018 SHALL make the latency fixed: start sampled at edge k gives done=1 during the cycle after edge k+WIDTH+1, independent of the operand values.
REQ-019 SHALL assert done for exactly one cycle (DONE state), with sum and cout valid in that cycle, then return to IDLE unconditionally.
REQ-020 SHALL hold sum and cout stable from DONE until the next accepted start.
- Intermediate shift contents are visible on sum during RUN.
- sum is valid only when done=1 or after it.
REQ-021 SHALL ignore start while in RUN or DONE: no capture, no restart, no effect on the result.
REQ-022 SHALL, for WIDTH=1, spend one RUN cycle and then enter DONE.
REQ-023 SHALL never drive busy and done high together; both are low in IDLE.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, force state IDLE and the following outputs: busy=0, done=0, sum=0, cout=0.
REQ-025 SHALL also clear the operand shift registers, the carry flop and the bit counter on reset.
REQ-026 SHALL make rst dominant over start at the same edge.
REQ-027 SHALL, when rst is asserted mid-RUN or in DONE, abort the operation with no done pulse; the first start after rst deasserts runs a full, correct addition.

Structure
REQ-028 SHALL take the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width constant from the shared package serial_add_pkg.
REQ-029 SHALL build the full-add slice from two instances of the existing half_adder module (ports A, B, Sum, Carry), ORing their carries; no other sub-module.
REQ-030 SHALL size the bit counter to hold WIDTH, i.e. clog2(WIDTH+1) bits.

Verification (WIDTH=8 unless stated)
REQ-031 SHALL cover: a=8'h00, b=8'h00, cin=0, start pulse -> busy for 8 cycles, then done=1 with sum=8'h00, cout=0.
REQ-032 SHALL cover: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple); done exactly 9 cycles after the start edge.
REQ-033 SHALL cover: a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; then a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0.
REQ-034 SHALL cover: start held high throughout with a=8'h12, b=8'h34 at capture, then operands changed to 8'hFF/8'hFF during RUN -> result sum=8'h46, cout=0; next op starts in the IDLE cycle after done.
REQ-035 SHALL cover: rst asserted at the 4th RUN cycle of a=8'hFF, b=8'hFF -> next cycle busy=0, done=0, sum=0, cout=0 and no done pulse; a new start with a=8'h01, b=8'h01 -> sum=8'h02.
REQ-036 SHALL cover, with WIDTH=4: all 512 (a, b, cin) combinations, with sum/cout compared against a+b+cin and the done latency checked as 5 cycles each.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_WIDTH = 32;

  // The bit counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder; two of these plus an OR make one full-add slice.
module half_adder (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B;
  assign Carry = A & B;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-add slice walks the operands LSB first.
// Result shifts in from the MSB end; done pulses WIDTH+1 edges after start is sampled.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             half_sum;
  logic             half_carry;
  logic             sum_bit;
  logic             prop_carry;
  logic             c_next;

  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] sum_shift;

  logic             accept;

  // Full-add slice: generate/propagate half adder, then fold in the running carry.
  half_adder u_ha_ab (
    .A     (a_q[0]),
    .B     (b_q[0]),
    .Sum   (half_sum),
    .Carry (half_carry)
  );

  half_adder u_ha_c (
    .A     (half_sum),
    .B     (c_q),
    .Sum   (sum_bit),
    .Carry (prop_carry)
  );

  assign c_next = half_carry | prop_carry;

  if (WIDTH == 1) begin : g_w1
    assign a_shift   = 1'b0;
    assign b_shift   = 1'b0;
    assign sum_shift = sum_bit;
  end else begin : g_wn
    assign a_shift   = {1'b0, a_q[WIDTH-1:1]};
    assign b_shift   = {1'b0, b_q[WIDTH-1:1]};
    assign sum_shift = {sum_bit, sum_q[WIDTH-1:1]};
  end

  assign accept = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      c_d   = cin;
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      a_d   = a_shift;
      b_d   = b_shift;
      c_d   = c_next;
      cnt_d = cnt_q + CW'(1);
      sum_d = sum_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
    end
  end

  // The carry flop ends the run holding bit WIDTH of the total.
  assign sum  = sum_q;
  assign cout = c_q;

endmodule
